// File: rtl/prod_accum_if.sv
// Product-in / sum-out val/rdy bundle for the product accumulator.
interface prod_accum_if #(
  parameter int p_width = 32
);
  logic               req_val;
  logic               req_rdy;
  logic [p_width-1:0] req_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_width-1:0] resp_msg;
  logic               resp_ovf;

  // Accumulator side: consumes products, produces sums.
  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg, resp_ovf
  );

  // Source/sink side: produces products, consumes sums.
  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg, resp_ovf
  );
endinterface

// File: rtl/prod_accum.sv
// Sums each group of p_nterms unsigned products into one wrapped result,
// with a sticky carry-out flag per group.
//
// state | meaning
// ------+------------------------------------------------------------
// ACC   | collecting products of the current group, req_rdy high
// DONE  | group sum presented; next group's first term may overlap
module prod_accum #(
  parameter int p_width  = 32,
  parameter int p_nterms = 4
) (
  input  logic         clk,
  input  logic         reset,
  prod_accum_if.slave  bus
);

  localparam int cw = $clog2(p_nterms + 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t             state, state_nxt;
  logic [p_width-1:0] acc, acc_nxt;
  logic [cw-1:0]      cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic [p_width:0]   sum;
  logic               last_term;

  logic               req_rdy;
  logic               resp_val;
  logic [p_width-1:0] resp_msg;
  logic               resp_ovf;

  // Widened add so the carry-out is visible for the sticky flag.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, bus.req_msg};
    last_term = (cnt == cw'(p_nterms - 1));
  end

  // Next-state and output decode; outputs are forced quiet while reset is high.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    resp_msg  = '0;
    resp_ovf  = 1'b0;
    case (state)
      ACC: begin
        req_rdy = 1'b1;
        if (bus.req_val) begin
          acc_nxt = sum[p_width-1:0];
          ovf_nxt = ovf | sum[p_width];
          if (last_term) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + cw'(1);
          end
        end
      end
      DONE: begin
        resp_val = 1'b1;
        resp_msg = acc;
        resp_ovf = ovf;
        req_rdy  = bus.resp_rdy;
        if (bus.resp_rdy) begin
          if (bus.req_val) begin
            // Overlap: the accepted product starts the next group.
            acc_nxt   = bus.req_msg;
            ovf_nxt   = 1'b0;
            cnt_nxt   = cw'(1);
            state_nxt = (p_nterms == 1) ? DONE : ACC;
          end else begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            state_nxt = ACC;
          end
        end
      end
      default: state_nxt = ACC;
    endcase
    if (reset) begin
      req_rdy  = 1'b0;
      resp_val = 1'b0;
      resp_msg = '0;
      resp_ovf = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign bus.req_rdy  = req_rdy;
  assign bus.resp_val = resp_val;
  assign bus.resp_msg = resp_msg;
  assign bus.resp_ovf = resp_ovf;

endmodule
